toaster_timer_pwm: RTL

Multi-channel countdown timer and heater PWM generator for the toaster controller, the parametrised successor to the single-channel timer. Each channel holds a seconds countdown and a duty-cycle value, and runs its own IDLE/RUN/PAUSED/DONE state machine. While a channel is in RUN it drives one heating-element PWM output. The block sits between the keypad/control logic, which loads time and duty, and the element drivers and 7-segment display path, which show the remaining time as BCD M:SS.

---
 rtl/toaster_timer_pwm_if.sv | 18 +
 rtl/toaster_timer_pwm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/toaster_timer_pwm_if.sv
// Load bus for toaster_timer_pwm: the keypad/control side writes time and duty
// into one channel and receives a one-cycle acknowledge.
interface toaster_timer_pwm_if #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned TIME_W = 10,
  parameter int unsigned DC_W   = 8
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              wr;
  logic [CH_W-1:0]   wr_ch;
  logic [TIME_W-1:0] wr_time;
  logic [DC_W-1:0]   wr_dc;
  logic              wr_ack;

  modport master (output wr, wr_ch, wr_time, wr_dc, input wr_ack);
  modport slave  (input wr, wr_ch, wr_time, wr_dc, output wr_ack);
endinterface

// File: rtl/toaster_timer_pwm.sv
// Multi-channel seconds countdown with per-channel heater PWM and BCD M:SS display.
// Optional pause support is built in when TOASTER_TIMER_PAUSE_EN is defined.
module toaster_timer_pwm #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned CLK_PER_SEC = 2000,
  parameter int unsigned TIME_W      = 10,
  parameter int unsigned DC_W        = 8,
  parameter int unsigned DC_MAX      = 200
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  toaster_timer_pwm_if.slave                        ld,
  input  logic [N_CH-1:0]                           start,
  input  logic [N_CH-1:0]                           stop,
  output logic [N_CH-1:0]                           pwm,
  output logic [N_CH-1:0]                           done,
  output logic [N_CH-1:0]                           busy,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] disp_ch,
  output logic [11:0]                               disp_bcd
);
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SEC_W = $clog2(CLK_PER_SEC);
  localparam int unsigned PWM_W = (DC_MAX > 1) ? $clog2(DC_MAX) : 1;
  localparam int unsigned T_MAX = 599;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StDone   = 2'd2
`ifdef TOASTER_TIMER_PAUSE_EN
    ,
    StPaused = 2'd3
`endif
  } state_e;

  state_e            st_q  [N_CH];
  state_e            st_d  [N_CH];
  logic [TIME_W-1:0] t_q   [N_CH];
  logic [TIME_W-1:0] t_d   [N_CH];
  logic [DC_W-1:0]   dc_q  [N_CH];
  logic [DC_W-1:0]   dc_d  [N_CH];
  logic [SEC_W-1:0]  sec_q [N_CH];
  logic [SEC_W-1:0]  sec_d [N_CH];
  logic [PWM_W-1:0]  pc_q  [N_CH];
  logic [PWM_W-1:0]  pc_d  [N_CH];

  logic [N_CH-1:0]   pwm_q, pwm_d, done_q, done_d, busy_q, busy_d, ld_hit;
  logic              wr_ack_q, wr_ack_d, ld_ok;
  logic [TIME_W-1:0] ld_time;
  logic [DC_W-1:0]   ld_dc;

  assign ld_ok    = ld.wr && (32'(ld.wr_ch) < N_CH);
  assign ld_time  = (32'(ld.wr_time) > T_MAX) ? TIME_W'(T_MAX) : ld.wr_time;
  assign ld_dc    = (32'(ld.wr_dc) > DC_MAX) ? DC_W'(DC_MAX) : ld.wr_dc;
  assign wr_ack_d = ld_ok;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ld_hit[i] = ld_ok && (ld.wr_ch == CH_W'(i));
    end
  end

  // Load is applied first; stop/start/tick then act on the post-load state.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]  = st_q[i];
      t_d[i]   = t_q[i];
      dc_d[i]  = dc_q[i];
      sec_d[i] = sec_q[i];
      pc_d[i]  = pc_q[i];

      if (ld_hit[i]) begin
        t_d[i]  = ld_time;
        dc_d[i] = ld_dc;
        if (ld_time == '0 && st_q[i] != StIdle && st_q[i] != StDone) begin
          st_d[i] = StIdle;
        end
      end

      case (st_d[i])
        StIdle: begin
          if (start[i] && !stop[i] && t_d[i] != '0) begin
            st_d[i]  = StRun;
            sec_d[i] = '0;
            pc_d[i]  = '0;
          end
        end
        StRun: begin
          if (stop[i]) begin
`ifdef TOASTER_TIMER_PAUSE_EN
            st_d[i] = StPaused;
`else
            st_d[i] = StIdle;
            t_d[i]  = '0;
`endif
          end else begin
            pc_d[i] = (pc_q[i] == PWM_W'(DC_MAX - 1)) ? '0 : pc_q[i] + 1'b1;
            if (sec_q[i] == SEC_W'(CLK_PER_SEC - 1)) begin
              sec_d[i] = '0;
              // A load in this cycle already set the time; skip the decrement.
              if (!ld_hit[i]) begin
                if (t_q[i] == TIME_W'(1)) begin
                  t_d[i]  = '0;
                  st_d[i] = StDone;
                end else begin
                  t_d[i] = t_q[i] - 1'b1;
                end
              end
            end else begin
              sec_d[i] = sec_q[i] + 1'b1;
            end
          end
        end
`ifdef TOASTER_TIMER_PAUSE_EN
        StPaused: begin
          if (stop[i]) begin
            st_d[i] = StIdle;
            t_d[i]  = '0;
          end else if (start[i]) begin
            st_d[i] = StRun;
          end
        end
`endif
        StDone:  st_d[i] = StIdle;
        default: st_d[i] = StIdle;
      endcase

      pwm_d[i]  = (st_d[i] == StRun) && (32'(pc_d[i]) < 32'(dc_d[i]));
      done_d[i] = (st_d[i] == StDone);
      busy_d[i] = (st_d[i] == StRun);
`ifdef TOASTER_TIMER_PAUSE_EN
      busy_d[i] = busy_d[i] | (st_d[i] == StPaused);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= StIdle;
        t_q[i]   <= '0;
        dc_q[i]  <= '0;
        sec_q[i] <= '0;
        pc_q[i]  <= '0;
      end
      pwm_q    <= '0;
      done_q   <= '0;
      busy_q   <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= st_d[i];
        t_q[i]   <= t_d[i];
        dc_q[i]  <= dc_d[i];
        sec_q[i] <= sec_d[i];
        pc_q[i]  <= pc_d[i];
      end
      pwm_q    <= pwm_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign pwm       = pwm_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign ld.wr_ack = wr_ack_q;

  logic [TIME_W-1:0] t_sel;
  int unsigned       tv, rem;

  // Time is clamped to 599, so the minutes digit always fits in 0..9.
  always_comb begin
    t_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (disp_ch == CH_W'(i)) t_sel = t_q[i];
    end
    tv       = 32'(t_sel);
    rem      = tv % 60;
    disp_bcd = {4'(tv / 60), 4'(rem / 10), 4'(tv % 10)};
  end

endmodule
